// File: rtl/fluxcore_pkg.sv
// Shared definitions for the fluxcore: opcodes, control FSM states and ALU mode codes.
// Imported by the control unit and the ALU so both agree on the encodings.
package fluxcore_pkg;

  typedef enum logic [3:0] {
    OpcNop = 4'h0,
    OpcAdd = 4'h1,
    OpcSub = 4'h2,
    OpcAnd = 4'h3,
    OpcOr  = 4'h4,
    OpcXor = 4'h5,
    OpcLdi = 4'h6,
    OpcJmp = 4'h7,
    OpcJz  = 4'h8,
    OpcJc  = 4'h9,
    OpcHlt = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StOperand,
    StExecute,
    StWriteback,
    StHalt
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  function automatic logic is_alu_op(input logic [3:0] opc);
    return opc inside {OpcAdd, OpcSub, OpcAnd, OpcOr, OpcXor};
  endfunction

  function automatic logic is_logic_op(input logic [3:0] opc);
    return opc inside {OpcAnd, OpcOr, OpcXor};
  endfunction

  // Two-byte instructions: the second byte is an immediate or a jump target.
  function automatic logic has_operand(input logic [3:0] opc);
    return opc inside {OpcLdi, OpcJmp, OpcJz, OpcJc};
  endfunction

  function automatic logic [2:0] alu_mode_of(input logic [3:0] opc);
    case (opc)
      OpcAdd:  return OP_ADD;
      OpcSub:  return OP_SUB;
      OpcAnd:  return OP_AND;
      OpcOr:   return OP_OR;
      OpcXor:  return OP_XOR;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Fluxcore control unit: fetch/decode FSM with PC, IR, operand and flag registers.
// Drives the external register file and registered ALU; memory uses a req/ack handshake.
module control_unit
  import fluxcore_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic [1:0]   rf_raddr_a,
  output logic [1:0]   rf_raddr_b,
  input  logic [N-1:0] rf_rdata_a,
  input  logic [N-1:0] rf_rdata_b,
  output logic         rf_we,
  output logic [1:0]   rf_waddr,
  output logic [N-1:0] rf_wdata,
  output logic         alu_enable,
  output logic [2:0]   alu_mode,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_carry,
  output logic         flag_z,
  output logic         flag_c,
  output logic         halted
);

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] ir_q, ir_d;
  logic [N-1:0] opnd_q, opnd_d;
  logic         flag_z_q, flag_z_d;
  logic         flag_c_q, flag_c_d;

  logic [3:0]   opc;
  logic [1:0]   rd;
  logic [1:0]   rs;
  logic [N-1:0] pc_inc;

  assign opc    = ir_q[7:4];
  assign rd     = ir_q[3:2];
  assign rs     = ir_q[1:0];
  assign pc_inc = pc_q + N'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ack) state_d = StDecode;
      end
      StDecode: begin
        if (is_alu_op(opc)) begin
          state_d = StExecute;
        end else if (has_operand(opc)) begin
          state_d = StOperand;
        end else if (opc == OpcHlt) begin
          state_d = StHalt;
        end else begin
          state_d = StFetch;
        end
      end
      StOperand: begin
        if (mem_ack) state_d = StWriteback;
      end
      StExecute:   state_d = StWriteback;
      StWriteback: state_d = StFetch;
      StHalt:      state_d = StHalt;
      default:     state_d = StFetch;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req    = 1'b0;
    alu_enable = 1'b0;
    rf_we      = 1'b0;
    rf_wdata   = alu_out;
    unique case (state_q)
      StFetch, StOperand: mem_req = 1'b1;
      StExecute:          alu_enable = 1'b1;
      StWriteback: begin
        if (is_alu_op(opc)) begin
          rf_we = 1'b1;
        end else if (opc == OpcLdi) begin
          rf_we    = 1'b1;
          rf_wdata = opnd_q;
        end
      end
      default: ;
    endcase
  end

  assign mem_addr   = pc_q;
  assign rf_raddr_a = rd;
  assign rf_raddr_b = rs;
  assign rf_waddr   = rd;
  assign alu_mode   = alu_mode_of(opc);
  assign alu_a      = rf_rdata_a;
  assign alu_b      = rf_rdata_b;
  assign flag_z     = flag_z_q;
  assign flag_c     = flag_c_q;
  assign halted     = (state_q == StHalt);

  // Datapath register updates
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    opnd_d   = opnd_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ack) begin
          ir_d = mem_rdata;
          pc_d = pc_inc;
        end
      end
      StOperand: begin
        if (mem_ack) begin
          opnd_d = mem_rdata;
          pc_d   = pc_inc;
        end
      end
      StWriteback: begin
        if (is_alu_op(opc)) begin
          flag_z_d = alu_zero;
          flag_c_d = is_logic_op(opc) ? 1'b0 : alu_carry;
        end
        case (opc)
          OpcJmp:  pc_d = opnd_q;
          OpcJz:   if (flag_z_q) pc_d = opnd_q;
          OpcJc:   if (flag_c_q) pc_d = opnd_q;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      ir_q     <= '0;
      opnd_q   <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opnd_q   <= opnd_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

endmodule
